// File: rtl/calc_cmd_issue_if.sv
// calc_cmd_issue_if: command intake and issue handshakes of the arithmetic front-end
interface calc_cmd_issue_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, issue_ready,
    input  cmd_ready, issue_valid, issue_op, issue_a, issue_b
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, issue_ready,
    output cmd_ready, issue_valid, issue_op, issue_a, issue_b
  );
endinterface

// File: rtl/calc_cmd_issue.sv
// calc_cmd_issue: in-order command FIFO feeding the arithmetic stage; define CALC_ISSUE_DZ_FILTER_EN to drop and count divide-by-zero commands
module calc_cmd_issue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  calc_cmd_issue_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   dz_err,
  output logic [7:0]             dz_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + 2 * WIDTH;
  localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_acc;
  logic          w_dz;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;
  assign bus.cmd_ready   = r_level != L_FULL;
  assign bus.issue_valid = r_level != '0;
  assign w_acc  = bus.cmd_valid && bus.cmd_ready;
  assign w_push = w_acc && !w_dz;
  assign w_pop  = bus.issue_valid && bus.issue_ready;
  assign w_head = bus.issue_valid ? r_mem[r_rp] : '0;
  assign bus.issue_op = w_head[EW-1 -: 2];
  assign bus.issue_a  = w_head[2*WIDTH-1 -: WIDTH];
  assign bus.issue_b  = w_head[WIDTH-1:0];
  assign level = r_level;
`ifdef CALC_ISSUE_DZ_FILTER_EN
  logic       r_dz_err;
  logic [7:0] r_dz_count;
  assign w_dz     = w_acc && bus.cmd_op == 2'd3 && bus.cmd_b == '0;
  assign dz_err   = r_dz_err;
  assign dz_count = r_dz_count;
  // one-cycle drop pulse and saturating drop count; flush leaves the count intact
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dz_err   <= 1'b0;
      r_dz_count <= '0;
    end else begin
      r_dz_err <= w_dz;
      if (w_dz && r_dz_count != 8'hFF) r_dz_count <= r_dz_count + 8'd1;
    end
  end
`else
  assign w_dz     = 1'b0;
  assign dz_err   = 1'b0;
  assign dz_count = '0;
`endif
  // storage write; stale entries are harmless since the pointers and level gate them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end
  // pointers and occupancy; reset beats flush, flush discards same-cycle push and pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_calc_cmd_issue.sv
// tb_calc_cmd_issue: scoreboard bench for calc_cmd_issue
module tb_calc_cmd_issue;
  localparam int W = 8;
  localparam int D = 4;
`ifdef CALC_ISSUE_DZ_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic         clk;
  logic         rst;
  logic         flush;
  logic [2:0]   level;
  logic         dz_err;
  logic [7:0]   dz_count;
  logic         chk_en;
  int           n_vec;
  int           n_err;
  int           m_level;
  logic         m_dz_err;
  int           m_dz_cnt;
  logic         m_acc;
  logic         m_dz;
  logic         m_pop;
  logic [17:0]  q[$];
  calc_cmd_issue_if #(.WIDTH(W)) bus ();
  calc_cmd_issue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .level(level), .dz_err(dz_err), .dz_count(dz_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic rdy, input logic fl);
    bus.cmd_valid = v;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.issue_ready = rdy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask
  // cycle model: check DUT against the model, then advance the model to the next edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level), 32'(m_level));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_level != D));
      chk("issue_valid", 32'(bus.issue_valid), 32'(m_level != 0));
      chk("dz_err", 32'(dz_err), 32'(m_dz_err));
      chk("dz_count", 32'(dz_count), 32'(m_dz_cnt));
      if (m_level != 0 && q.size() != 0) begin
        chk("issue_op", 32'(bus.issue_op), 32'(q[0][17:16]));
        chk("issue_a", 32'(bus.issue_a), 32'(q[0][15:8]));
        chk("issue_b", 32'(bus.issue_b), 32'(q[0][7:0]));
      end
    end
    if (rst) begin
      m_level = 0;
      m_dz_err = 1'b0;
      m_dz_cnt = 0;
      q.delete();
    end else begin
      m_acc = bus.cmd_valid && m_level != D;
      m_dz = m_acc && FILT && bus.cmd_op == 2'd3 && bus.cmd_b == 8'd0;
      m_pop = m_level != 0 && bus.issue_ready;
      m_dz_err = m_dz;
      if (m_dz && m_dz_cnt != 255) m_dz_cnt++;
      if (flush) begin
        m_level = 0;
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc && !m_dz) q.push_back({bus.cmd_op, bus.cmd_a, bus.cmd_b});
        m_level = m_level + int'(m_acc && !m_dz) - int'(m_pop);
      end
    end
  end
  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_a = 8'd0;
    bus.cmd_b = 8'd0;
    bus.issue_ready = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_issue_valid", 32'(bus.issue_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_dz_count", 32'(dz_count), 0);
    chk("rst_dz_err", 32'(dz_err), 0);
    chk("rst_issue_op", 32'(bus.issue_op), 0);
    chk("rst_issue_a", 32'(bus.issue_a), 0);
    chk("rst_issue_b", 32'(bus.issue_b), 0);
    cyc(1, 0, 3, 5, 1, 0);
    cyc(1, 1, 9, 4, 1, 0);
    cyc(1, 2, 2, 6, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 1, 0, 0);
    chk("bp_full_level", 32'(level), 4);
    chk("bp_full_ready", 32'(bus.cmd_ready), 0);
    repeat (2) cyc(1, 0, 5, 1, 1, 0);
    repeat (6) cyc(0, 0, 0, 0, 1, 0);
    chk("bp_drain_level", 32'(level), 0);
    cyc(1, 3, 7, 0, 1, 0);
    cyc(1, 3, 8, 2, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    chk("dz_count_one", 32'(dz_count), FILT ? 1 : 0);
    cyc(1, 0, 8'h11, 8'h22, 0, 0);
    cyc(1, 1, 8'h33, 8'h44, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 2'(i), 8'(i * 17 + 1), 8'(i + 100), 1, 0);
    chk("pp_level", 32'(level), 2);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'(i + 40), 8'(i), 0, 0);
    cyc(1, 0, 8'h77, 8'h01, 0, 1);
    chk("fl_level", 32'(level), 0);
    chk("fl_issue_valid", 32'(bus.issue_valid), 0);
    chk("fl_dz_count", 32'(dz_count), FILT ? 1 : 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 2, 8'h55, 8'h66, 0, 0);
    cyc(1, 3, 8'h99, 8'h03, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 8'h12, 8'h34, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(bus.issue_valid), 0);
    for (int i = 0; i < 260; i++) cyc(1, 3, 8'(i), 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    chk("dz_saturate", 32'(dz_count), FILT ? 255 : 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calc_cmd_issue.md
Name: calc_cmd_issue

Overview:
- Upstream command front-end for the add/substract/multiply/divide arithmetic stage.
- Accepts operand-pair commands through a valid/ready handshake and buffers them in a small FIFO.
- Issues commands in order to the arithmetic stage through a second valid/ready handshake.
- Filters divide-by-zero commands before they reach the divider, and counts them.

Parameters:
- WIDTH, 8, operand width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous FIFO clear.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  upstream command ready.
- cmd_op  input  2  operation: 0=add, 1=sub, 2=mul, 3=div.
- cmd_a  input  WIDTH  operand 1.
- cmd_b  input  WIDTH  operand 2.
- issue_valid  output  1  command valid toward the arithmetic stage.
- issue_ready  input  1  arithmetic stage accepts the command.
- issue_op  output  2  head-of-FIFO opcode.
- issue_a  output  WIDTH  head-of-FIFO operand 1.
- issue_b  output  WIDTH  head-of-FIFO operand 2.
- level  output  $clog2(DEPTH)+1  number of FIFO entries.
- dz_err  output  1  one-cycle pulse when a divide-by-zero command is dropped.
- dz_count  output  8  saturating count of dropped divide-by-zero commands.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs are registered or derived from registers.
  - At reset: issue_valid=0, issue_op/a/b=0, level=0, dz_err=0, dz_count=0, cmd_ready=1.
  - Reset asserted mid-transfer discards all entries; no partial state survives.
- Accept rule:
  - A command is accepted on a cycle where cmd_valid=1 and cmd_ready=1.
  - cmd_ready = (level != DEPTH).
  - cmd_ready depends on registered state only; there is no combinational path from issue_ready.
- Divide-by-zero drop:
  - An accepted command with cmd_op=3 and cmd_b=0 is not written to the FIFO.
  - dz_err pulses high on the next cycle.
  - dz_count increments and saturates at 255.
  - The drop still requires cmd_ready=1.
- Push: any other accepted command is written at the write pointer, and the write pointer increments modulo DEPTH.
- Issue:
  - issue_valid = (level != 0).
  - issue_op/a/b present the head entry and stay stable while issue_valid=1 and issue_ready=0.
  - Latency: a command pushed into an empty FIFO at edge N appears with issue_valid=1 after edge N (visible in cycle N+1).
- Pop: a command is popped when issue_valid=1 and issue_ready=1; the read pointer increments modulo DEPTH.
- Level update:
  - Push only: level +1.
  - Pop only: level −1.
  - Push and pop in the same cycle: level unchanged, and both pointers advance.
- Boundaries:
  - Full (level=DEPTH): cmd_ready=0. A pop in that cycle frees the slot for the next cycle, not the current one.
  - Empty: issue_ready is ignored.
  - A dropped divide-by-zero command arriving in the same cycle as a pop gives level −1.
- Flush:
  - Takes effect at the next edge: both pointers reset to 0, level=0, issue_valid=0.
  - dz_count is kept.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle is also discarded; the downstream stage must not rely on it.
  - rst has priority over flush.
- Ordering: strict FIFO order; commands are neither reordered nor duplicated.

Optional Feature:
- Macro: CALC_ISSUE_DZ_FILTER_EN.
- Defined: divide-by-zero filtering, dz_err and dz_count operate exactly as described above.
- Undefined:
  - All commands, including div with cmd_b=0, are pushed unchanged.
  - dz_err and dz_count are tied to 0.
  - Area for the filter and counter is removed.

Test Plan:
- Reset then idle: hold rst 2 cycles → issue_valid=0, level=0, cmd_ready=1, dz_count=0.
- Basic flow with issue_ready=1:
  - Stimulus: push (add,3,5), (sub,9,4), (mul,2,6).
  - Response: issued in order one cycle after each push; level never exceeds 1.
- Backpressure:
  - Stimulus: issue_ready=0, push 5 commands with op=0 and a=1..5, b=1.
  - Response: first 4 accepted, level=4, cmd_ready=0 on the 5th.
  - Then raise issue_ready: a=1..4 emerge in order, the 5th is accepted after the first pop, and level returns to 0.
- Divide by zero (filter enabled):
  - Stimulus: push (div,7,0) then (div,8,2).
  - Response: the first is dropped with dz_err pulsed once and dz_count=1; only (div,8,2) is issued.
  - With the macro undefined: both are issued and dz_count=0.
- Simultaneous push/pop at level=2 → level stays 2; pointers wrap correctly across 10 such cycles with DEPTH=4.
- Flush with 3 entries queued plus a push in the same cycle → next cycle level=0, issue_valid=0; dz_count is unchanged.
